// File: rtl/spectrum_frame_ctrl.sv
// spectrum_frame_ctrl
// -------------------
// Sequences FFT output frames into the bin-select stage of the log-mel
// pipeline. Each accepted FFT sample is tagged with its bin index
// (0..N_FFT-1) and its mel group number. Only bins 0..KEEP_BINS-1 are
// forwarded. Completed frames are counted against a programmed job length.
//
// Mel group boundaries are held in a NUM_GRP-entry register table. Each
// entry is the last bin index of its group (inclusive). The table can be
// written through the config port only while the block is not running.
//
// Optional feature:
//   SFC_DROP_STATS_EN - when defined, adds drop_cnt[15:0]. This counter
//                       counts fft_valid samples dropped outside RUN. It
//                       saturates at 16'hFFFF and is cleared by rst and by
//                       an accepted start.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   pulse: begin a job of num_frames frames (IDLE only)
//   num_frames   in   frames per job, sampled on accepted start
//   fft_valid    in   FFT sample valid
//   fft_data     in   signed FFT sample
//   cfg_we       in   group table write strobe
//   cfg_addr     in   group slot
//   cfg_data     in   last bin index of that group
//   sel_en       out  forwarded sample valid (registered)
//   sel_data     out  forwarded sample
//   sel_idx      out  bin index of forwarded sample, zero-extended
//   sel_grp      out  mel group of forwarded sample
//   frame_done   out  1-cycle pulse after the last bin of a frame
//   job_done     out  1-cycle pulse when the job completes
//   busy         out  high while running
//   frame_cnt    out  frames completed in current job
//   cfg_err      out  sticky: a config write was rejected
//   drop_cnt     out  (SFC_DROP_STATS_EN only) dropped-sample count

module spectrum_frame_ctrl #(
  parameter int unsigned I_BW      = 14,
  parameter int unsigned N_FFT     = 1024,
  parameter int unsigned KEEP_BINS = 513,
  parameter int unsigned NUM_GRP   = 89,
  parameter int unsigned FRM_BW    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [FRM_BW-1:0]      num_frames,
  input  logic                   fft_valid,
  input  logic signed [I_BW-1:0] fft_data,
  input  logic                   cfg_we,
  input  logic [6:0]             cfg_addr,
  input  logic [9:0]             cfg_data,
  output logic                   sel_en,
  output logic signed [I_BW-1:0] sel_data,
  output logic [9:0]             sel_idx,
  output logic [6:0]             sel_grp,
  output logic                   frame_done,
  output logic                   job_done,
  output logic                   busy,
  output logic [FRM_BW-1:0]      frame_cnt,
  output logic                   cfg_err
`ifdef SFC_DROP_STATS_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int unsigned BinW = $clog2(N_FFT);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [BinW-1:0]        bin_q, bin_d;
  logic [6:0]             grp_q, grp_d;
  logic [FRM_BW-1:0]      frame_cnt_q, frame_cnt_d;
  logic [FRM_BW-1:0]      num_frames_q, num_frames_d;
  logic                   sel_en_q, sel_en_d;
  logic signed [I_BW-1:0] sel_data_q, sel_data_d;
  logic [9:0]             sel_idx_q, sel_idx_d;
  logic [6:0]             sel_grp_q, sel_grp_d;
  logic                   frame_done_q, frame_done_d;
  logic                   job_done_q, job_done_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   cfg_wr;

  // Group boundary table: entry g is the last bin of group g.
  logic [9:0]             tbl_q [NUM_GRP];

`ifdef SFC_DROP_STATS_EN
  logic                   start_ok;
  logic                   drop;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
`endif

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    grp_d        = grp_q;
    frame_cnt_d  = frame_cnt_q;
    num_frames_d = num_frames_q;
    sel_en_d     = 1'b0;
    sel_data_d   = sel_data_q;
    sel_idx_d    = sel_idx_q;
    sel_grp_d    = sel_grp_q;
    frame_done_d = 1'b0;
    job_done_d   = 1'b0;
    cfg_err_d    = cfg_err_q;
    cfg_wr       = 1'b0;
`ifdef SFC_DROP_STATS_EN
    start_ok     = 1'b0;
    drop         = fft_valid && (state_q != StRun);
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
`ifdef SFC_DROP_STATS_EN
          start_ok = 1'b1;
`endif
          num_frames_d = num_frames;
          bin_d        = '0;
          grp_d        = '0;
          frame_cnt_d  = '0;
          // A zero-length job completes without ever entering RUN.
          state_d      = (num_frames != '0) ? StRun : StDone;
        end
      end

      StRun: begin
        if (fft_valid) begin
          if (32'(bin_q) < KEEP_BINS) begin
            sel_en_d   = 1'b1;
            sel_data_d = fft_data;
            sel_idx_d  = 10'(bin_q);
            sel_grp_d  = grp_q;
          end

          if (32'(bin_q) == N_FFT - 1) begin
            // Frame wrap takes priority over any group advance.
            bin_d        = '0;
            grp_d        = '0;
            frame_cnt_d  = frame_cnt_q + 1'b1;
            frame_done_d = 1'b1;
            if (frame_cnt_d == num_frames_q) begin
              state_d = StDone;
            end
          end else begin
            bin_d = bin_q + 1'b1;
            // Advance after tagging; the last group absorbs all later bins.
            if ((tbl_q[grp_q] == 10'(bin_q)) && (32'(grp_q) < NUM_GRP - 1)) begin
              grp_d = grp_q + 1'b1;
            end
          end
        end
      end

      StDone: begin
        job_done_d = 1'b1;
        state_d    = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Table writes are only safe while no frame is being tagged.
    if (cfg_we) begin
      if ((state_q != StRun) && (32'(cfg_addr) < NUM_GRP)) begin
        cfg_wr = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

`ifdef SFC_DROP_STATS_EN
    drop_cnt_d = drop_cnt_q;
    if (start_ok) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      bin_q        <= '0;
      grp_q        <= '0;
      frame_cnt_q  <= '0;
      num_frames_q <= '0;
      sel_en_q     <= 1'b0;
      sel_data_q   <= '0;
      sel_idx_q    <= '0;
      sel_grp_q    <= '0;
      frame_done_q <= 1'b0;
      job_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      grp_q        <= grp_d;
      frame_cnt_q  <= frame_cnt_d;
      num_frames_q <= num_frames_d;
      sel_en_q     <= sel_en_d;
      sel_data_q   <= sel_data_d;
      sel_idx_q    <= sel_idx_d;
      sel_grp_q    <= sel_grp_d;
      frame_done_q <= frame_done_d;
      job_done_q   <= job_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Group boundary table
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GRP; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (cfg_wr) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

`ifdef SFC_DROP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sel_en     = sel_en_q;
  assign sel_data   = sel_data_q;
  assign sel_idx    = sel_idx_q;
  assign sel_grp    = sel_grp_q;
  assign frame_done = frame_done_q;
  assign job_done   = job_done_q;
  assign busy       = (state_q == StRun);
  assign frame_cnt  = frame_cnt_q;
  assign cfg_err    = cfg_err_q;

endmodule
